regfile_mp: RTL and testbench
=============================

REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 Parameter DATA_W, default 32: register width in bits.
REQ-002 Parameter ADDR_W, default 5: register address width; depth is 2^ADDR_W.
REQ-003 Parameter NUM_RD, default 2: number of read ports, from 1 to 4.
REQ-004 Parameter NUM_WR, default 2: number of write ports, from 1 to 2.
REQ-005 clk  in  1  single clock; all state updates on its rising edge.
REQ-006 rst  in  1  reset, asynchronous assert, active-low (0 = reset).
REQ-007 we  in  NUM_WR  per-write-port enable; port k occupies bit k.
REQ-008 waddr  in  NUM_WR*ADDR_W  write addresses; port k occupies slice k.
REQ-009 wdata  in  NUM_WR*DATA_W  write data; port k occupies slice k.
REQ-010 re  in  NUM_RD  per-read-port enable.
REQ-011 raddr  in  NUM_RD*ADDR_W  read addresses.
REQ-012 rdata  out  NUM_RD*DATA_W  read data, combinational.
REQ-013 rbusy  out  NUM_RD  read port j targets a register with an unresolved pending write (hazard flag).
REQ-014 iss_en  in  1  issue strobe: mark iss_addr pending.
REQ-015 iss_addr  in  ADDR_W  destination register being issued.
REQ-016 busy_vec  out  2^ADDR_W  registered per-register pending bits.

Function
REQ-017 The storage array SHALL hold 2^ADDR_W x DATA_W bits; register 0 SHALL always read as 0 and SHALL ignore writes.
REQ-018 On a rising clk edge with we[k]=1 and waddr[k]!=0, the register at waddr[k] SHALL load wdata[k].
REQ-019 If both write ports target the same nonzero address in one cycle, port NUM_WR-1 SHALL win; the other port's data SHALL be discarded.
REQ-020 rdata[j] SHALL be 0 when rst=0, re[j]=0, or raddr[j]=0.
REQ-021 Otherwise rdata[j] SHALL be the wdata of the highest-index write port with we=1 and waddr==raddr[j] (same-cycle bypass), or, if no port matches, regs[raddr[j]].
REQ-022 Read latency SHALL be 0 cycles; write-to-read latency through the array SHALL be 1 cycle, and through the bypass it SHALL be 0 cycles.
REQ-023 Scoreboard: on a rising edge with iss_en=1 and iss_addr!=0, busy_vec[iss_addr] SHALL set to 1.
REQ-024 On a rising edge, busy_vec[waddr[k]] SHALL clear for every port k with we[k]=1, unless a set of the same bit occurs in that same cycle.
REQ-025 A simultaneous issue and writeback to the same register SHALL leave the bit set, because the issue is the newer producer.
REQ-026 busy_vec[0] SHALL be constant 0.
REQ-027 rbusy[j] SHALL be 1 only when re[j]=1, raddr[j]!=0, busy_vec[raddr[j]]=1, and no write port writes raddr[j] in the current cycle; a bypassed write resolves the hazard.
REQ-028 rbusy SHALL be 0 while rst=0.
REQ-029 Reads SHALL have no side effect on the array or the scoreboard.
REQ-030 Out-of-range parameters SHALL cause an elaboration-time error.

Reset
REQ-031 While rst=0, all registers SHALL be cleared to 0 asynchronously and busy_vec SHALL be all 0.
REQ-032 While rst=0, writes and issues SHALL be ignored, and rdata and rbusy SHALL be all 0.
REQ-033 Reset deassertion SHALL be synchronised externally; the first write SHALL be accepted on the first rising edge with rst=1.
REQ-034 Assertion of rst mid-operation SHALL discard any in-flight write and clear all state within the same cycle, with no clock required.

Verification
REQ-035 Reset check: write 0xDEADBEEF to r5, assert rst=0 without clk, release, read r5 -> rdata=0 and busy_vec=0.
REQ-036 Bypass and zero register:
- Same cycle: we[0]=1, waddr=3, wdata=0x1234, re[0]=1, raddr=3 -> rdata[0]=0x1234 before the edge; after the edge, with we=0, it still reads 0x1234.
- Write to r0 -> reads back 0.
REQ-037 Write collision: port0 writes r7=0xAAAA and port1 writes r7=0x5555 in the same cycle -> r7=0x5555 next cycle; a same-cycle read of r7 also returns 0x5555.
REQ-038 Scoreboard:
- Issue r9 -> busy_vec[9]=1 next cycle.
- Read r9 -> rbusy=1.
- Writeback to r9 -> rbusy=0 in that cycle and busy_vec[9]=0 afterwards.
REQ-039 Simultaneous set/clear: busy r4, then in one cycle issue r4 and write r4=0x77 -> busy_vec[4] stays 1 and r4=0x77.
REQ-040 Parameter sweep: NUM_RD=4, NUM_WR=1, DATA_W=64, ADDR_W=6 -> random write/read traffic matches a reference model over 10k cycles.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-port register file with same-cycle write bypass and a per-register
// pending-write scoreboard used to flag read-after-issue hazards.
module regfile_mp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_WR-1:0]        we,
  input  logic [NUM_WR*ADDR_W-1:0] waddr,
  input  logic [NUM_WR*DATA_W-1:0] wdata,
  input  logic [NUM_RD-1:0]        re,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  output logic [NUM_RD-1:0]        rbusy,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  output logic [(1<<ADDR_W)-1:0]   busy_vec
);

  localparam int DEPTH = 1 << ADDR_W;

  generate
    if (NUM_RD < 1 || NUM_RD > 4) begin : g_bad_num_rd
      $error("regfile_mp: NUM_RD must be in 1..4");
    end
    if (NUM_WR < 1 || NUM_WR > 2) begin : g_bad_num_wr
      $error("regfile_mp: NUM_WR must be in 1..2");
    end
    if (DATA_W < 1 || ADDR_W < 1) begin : g_bad_width
      $error("regfile_mp: DATA_W and ADDR_W must be positive");
    end
  endgenerate

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy_nxt;

  // Later write ports are applied last, so the highest index wins a collision.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else begin
      for (int k = 0; k < NUM_WR; k++) begin
        if (we[k] && waddr[k*ADDR_W +: ADDR_W] != '0)
          regs[waddr[k*ADDR_W +: ADDR_W]] <= wdata[k*DATA_W +: DATA_W];
      end
    end
  end

  // Clear on writeback first, then set on issue: the issue is the newer producer.
  always_comb begin
    busy_nxt = busy_vec;
    for (int k = 0; k < NUM_WR; k++) begin
      if (we[k]) busy_nxt[waddr[k*ADDR_W +: ADDR_W]] = 1'b0;
    end
    if (iss_en && iss_addr != '0) busy_nxt[iss_addr] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) busy_vec <= '0;
    else      busy_vec <= busy_nxt;
  end

  generate
    for (genvar j = 0; j < NUM_RD; j++) begin : g_rd
      logic [ADDR_W-1:0] ra;
      logic [DATA_W-1:0] rval;
      logic              hit;
      logic              active;

      assign ra     = raddr[j*ADDR_W +: ADDR_W];
      assign active = rst && re[j] && (ra != '0);

      always_comb begin
        rval = regs[ra];
        hit  = 1'b0;
        for (int k = 0; k < NUM_WR; k++) begin
          if (we[k] && waddr[k*ADDR_W +: ADDR_W] == ra) begin
            rval = wdata[k*DATA_W +: DATA_W];
            hit  = 1'b1;
          end
        end
      end

      assign rdata[j*DATA_W +: DATA_W] = active ? rval : '0;
      assign rbusy[j] = active && busy_vec[ra] && !hit;
    end
  endgenerate

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: directed checks on the default 2R/2W build and
// random traffic against a reference model on a 4R/1W, 64-bit, 64-entry build.
module tb_regfile_mp;

  logic clk;
  logic rst;

  // default instance: DATA_W=32, ADDR_W=5, NUM_RD=2, NUM_WR=2
  logic [1:0]  we_a;
  logic [9:0]  waddr_a;
  logic [63:0] wdata_a;
  logic [1:0]  re_a;
  logic [9:0]  raddr_a;
  logic [63:0] rdata_a;
  logic [1:0]  rbusy_a;
  logic        iss_en_a;
  logic [4:0]  iss_addr_a;
  logic [31:0] busy_vec_a;

  // swept instance: DATA_W=64, ADDR_W=6, NUM_RD=4, NUM_WR=1
  logic [0:0]   we_b;
  logic [5:0]   waddr_b;
  logic [63:0]  wdata_b;
  logic [3:0]   re_b;
  logic [23:0]  raddr_b;
  logic [255:0] rdata_b;
  logic [3:0]   rbusy_b;
  logic         iss_en_b;
  logic [5:0]   iss_addr_b;
  logic [63:0]  busy_vec_b;

  int n_vec = 0;
  int n_err = 0;
  logic [63:0] exp_q[$];

  logic [63:0] m_regs [64];
  logic [63:0] m_busy;

  regfile_mp dut_a (
    .clk(clk), .rst(rst),
    .we(we_a), .waddr(waddr_a), .wdata(wdata_a),
    .re(re_a), .raddr(raddr_a), .rdata(rdata_a), .rbusy(rbusy_a),
    .iss_en(iss_en_a), .iss_addr(iss_addr_a), .busy_vec(busy_vec_a)
  );

  regfile_mp #(.DATA_W(64), .ADDR_W(6), .NUM_RD(4), .NUM_WR(1)) dut_b (
    .clk(clk), .rst(rst),
    .we(we_b), .waddr(waddr_b), .wdata(wdata_b),
    .re(re_b), .raddr(raddr_b), .rdata(rdata_b), .rbusy(rbusy_b),
    .iss_en(iss_en_b), .iss_addr(iss_addr_b), .busy_vec(busy_vec_b)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic idle_a();
    we_a = '0; waddr_a = '0; wdata_a = '0;
    re_a = '0; raddr_a = '0; iss_en_a = 1'b0; iss_addr_a = '0;
  endtask

  task automatic idle_b();
    we_b = '0; waddr_b = '0; wdata_b = '0;
    re_b = '0; raddr_b = '0; iss_en_b = 1'b0; iss_addr_b = '0;
  endtask

  task automatic write_a(input int port, input logic [4:0] addr, input logic [31:0] data);
    we_a[port] = 1'b1;
    waddr_a[port*5 +: 5] = addr;
    wdata_a[port*32 +: 32] = data;
  endtask

  task automatic read_a(input int port, input logic [4:0] addr);
    re_a[port] = 1'b1;
    raddr_a[port*5 +: 5] = addr;
  endtask

  function automatic logic [5:0] pick_addr();
    if ($urandom_range(0, 1) == 1) return 6'($urandom_range(0, 7));
    return 6'($urandom_range(0, 63));
  endfunction

  task automatic rand_cycle_b();
    logic [5:0]  a;
    logic [63:0] e;
    logic        h;
    @(negedge clk);
    we_b       = 1'($urandom_range(0, 1));
    waddr_b    = pick_addr();
    wdata_b    = {$urandom, $urandom};
    iss_en_b   = ($urandom_range(0, 3) == 0);
    iss_addr_b = pick_addr();
    re_b       = 4'($urandom_range(0, 15));
    for (int j = 0; j < 4; j++) raddr_b[j*6 +: 6] = pick_addr();
    // scoreboard: expected read data, hazard flag per port, then busy vector
    for (int j = 0; j < 4; j++) begin
      a = raddr_b[j*6 +: 6];
      e = '0;
      h = 1'b0;
      if (re_b[j] && a != 6'd0) begin
        if (we_b[0] && waddr_b == a) e = wdata_b;
        else begin
          e = m_regs[a];
          h = m_busy[a];
        end
      end
      exp_q.push_back(e);
      exp_q.push_back({63'd0, h});
    end
    exp_q.push_back(m_busy);
    #2;
    for (int j = 0; j < 4; j++) begin
      check("rand_rdata", rdata_b[j*64 +: 64], exp_q.pop_front());
      check("rand_rbusy", {63'd0, rbusy_b[j]}, exp_q.pop_front());
    end
    check("rand_busy_vec", busy_vec_b, exp_q.pop_front());
    if (we_b[0] && waddr_b != 6'd0) m_regs[waddr_b] = wdata_b;
    if (we_b[0]) m_busy[waddr_b] = 1'b0;
    if (iss_en_b && iss_addr_b != 6'd0) m_busy[iss_addr_b] = 1'b1;
    m_busy[0] = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    idle_a();
    idle_b();
    for (int i = 0; i < 64; i++) m_regs[i] = '0;
    m_busy = '0;

    // reset state, writes ignored while in reset
    @(negedge clk);
    write_a(0, 5'd8, 32'h1);
    read_a(0, 5'd8);
    #2;
    check("rst_rdata", rdata_a, 64'd0);
    check("rst_busy_vec", {32'd0, busy_vec_a}, 64'd0);
    check("rst_busy_vec_b", busy_vec_b, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    idle_a();
    read_a(0, 5'd8);
    #2;
    check("rst_write_ignored", {32'd0, rdata_a[31:0]}, 64'd0);

    // async reset clears a written register and the scoreboard without a clock
    @(negedge clk);
    idle_a();
    write_a(0, 5'd5, 32'hDEADBEEF);
    iss_en_a = 1'b1; iss_addr_a = 5'd6;
    @(negedge clk);
    idle_a();
    read_a(0, 5'd5);
    #2;
    check("pre_rst_r5", {32'd0, rdata_a[31:0]}, 64'h0000_0000_DEAD_BEEF);
    check("pre_rst_busy", {32'd0, busy_vec_a}, 64'h40);
    rst = 1'b0;
    #1;
    check("async_rst_rdata", {32'd0, rdata_a[31:0]}, 64'd0);
    check("async_rst_busy", {32'd0, busy_vec_a}, 64'd0);
    rst = 1'b1;
    @(negedge clk);
    #2;
    check("post_rst_r5", {32'd0, rdata_a[31:0]}, 64'd0);
    check("post_rst_busy", {32'd0, busy_vec_a}, 64'd0);

    // same-cycle bypass, then array read
    @(negedge clk);
    idle_a();
    write_a(0, 5'd3, 32'h1234);
    read_a(0, 5'd3);
    read_a(1, 5'd3);
    #2;
    check("bypass_p0", {32'd0, rdata_a[31:0]}, 64'h1234);
    check("bypass_p1", {32'd0, rdata_a[63:32]}, 64'h1234);
    @(negedge clk);
    idle_a();
    read_a(1, 5'd3);
    #2;
    check("array_r3", {32'd0, rdata_a[63:32]}, 64'h1234);

    // register 0 ignores writes
    @(negedge clk);
    idle_a();
    write_a(1, 5'd0, 32'hFFFF_FFFF);
    read_a(0, 5'd0);
    #2;
    check("r0_same_cycle", {32'd0, rdata_a[31:0]}, 64'd0);
    @(negedge clk);
    idle_a();
    read_a(0, 5'd0);
    #2;
    check("r0_after", {32'd0, rdata_a[31:0]}, 64'd0);

    // write collision: port 1 wins in both the bypass and the array
    @(negedge clk);
    idle_a();
    write_a(0, 5'd7, 32'hAAAA);
    write_a(1, 5'd7, 32'h5555);
    read_a(0, 5'd7);
    #2;
    check("collide_bypass", {32'd0, rdata_a[31:0]}, 64'h5555);
    @(negedge clk);
    idle_a();
    read_a(0, 5'd7);
    #2;
    check("collide_array", {32'd0, rdata_a[31:0]}, 64'h5555);

    // scoreboard: issue, hazard, writeback resolves hazard
    @(negedge clk);
    idle_a();
    iss_en_a = 1'b1; iss_addr_a = 5'd9;
    @(negedge clk);
    idle_a();
    read_a(0, 5'd9);
    #2;
    check("issue_busy_vec", {32'd0, busy_vec_a}, 64'h200);
    check("hazard_rbusy", {62'd0, rbusy_a}, 64'h1);
    @(negedge clk);
    idle_a();
    write_a(0, 5'd9, 32'h99);
    read_a(0, 5'd9);
    #2;
    check("wb_rbusy", {62'd0, rbusy_a}, 64'h0);
    check("wb_bypass", {32'd0, rdata_a[31:0]}, 64'h99);
    @(negedge clk);
    idle_a();
    #2;
    check("wb_busy_clear", {32'd0, busy_vec_a}, 64'd0);

    // simultaneous issue and writeback leaves the bit set
    @(negedge clk);
    idle_a();
    iss_en_a = 1'b1; iss_addr_a = 5'd4;
    @(negedge clk);
    idle_a();
    iss_en_a = 1'b1; iss_addr_a = 5'd4;
    write_a(1, 5'd4, 32'h77);
    @(negedge clk);
    idle_a();
    read_a(1, 5'd4);
    #2;
    check("setclr_busy_vec", {32'd0, busy_vec_a}, 64'h10);
    check("setclr_r4", {32'd0, rdata_a[63:32]}, 64'h77);
    check("setclr_rbusy", {62'd0, rbusy_a}, 64'h2);
    @(negedge clk);
    idle_a();

    // random traffic on the swept instance
    for (int c = 0; c < 10000; c++) rand_cycle_b();
    @(negedge clk);
    idle_b();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
